// File: rtl/mcs4_pad_pkg.sv
// Shared definitions for the MCS-4 pad-ring controller.
// Holds the controller state encoding and the default parameter values
// used by mcs4_pad_ctrl. No ports.
package mcs4_pad_pkg;

    // The encodings are visible on state_dbg, so they are fixed explicitly.
    // ST_ILLEGAL is never entered; if it shows up, the FSM recovers via HOLD.
    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RUN     = 2'd2,
        ST_ILLEGAL = 2'd3
    } pad_state_e;

    localparam int DEF_N_POUT      = 10;
    localparam int DEF_N_IO        = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_CYCLES = 4;
    localparam int DEF_HOLD_CYCLES = 16;

endpackage

// File: rtl/mcs4_sync_bus.sv
// W-bit multi-flop synchroniser for signals arriving asynchronously from
// the pad cells. Each bit is synchronised on its own, so a multi-bit bus is
// only coherent if the source holds it stable for several cycles.
// Ports:
//   clk    in  1  sampling clock
//   rst_n  in  1  asynchronous active-low reset, clears every stage
//   d_i    in  W  asynchronous input
//   q_o    out W  synchronised output, STAGES edges after d_i
module mcs4_sync_bus #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/mcs4_pad_ctrl.sv
// Pad-ring controller between the MCS-4 core and the PADDI/PADDO pad cells.
// - Synchronises and glitch-filters the CLEAR pad input.
// - Sequences core reset: RESET -> HOLD (HOLD_CYCLES clean cycles) -> RUN.
// - Registers every pad-bound output and forces safe values outside RUN.
// - Synchronises the IO pad receivers back to the core.
// Ports:
//   sysclk        in   1       system clock, rising edge
//   poc_n         in   1       power-on clear, asynchronous, active-low
//   clear_pad_in  in   1       raw CLEAR from pad, async to sysclk
//   core_clear    out  1       core reset, active-high (state != RUN)
//   ready         out  1       1 while in RUN
//   state_dbg     out  2       current FSM state encoding
//   core_p_out    in   N_POUT  core output data
//   core_io_out   in   N_IO    core IO output data
//   core_io_oe    in   N_IO    core IO output enable, 1 = drive
//   core_io_in    out  N_IO    synchronised IO pad input to core
//   pad_p_out     out  N_POUT  to output pad cells
//   pad_io_a      out  N_IO    to IO pad cell data input
//   pad_io_oe     out  N_IO    to IO pad cell enable
//   pad_io_y      in   N_IO    from IO pad cell receiver
module mcs4_pad_ctrl
    import mcs4_pad_pkg::*;
#(
    parameter int                N_POUT      = DEF_N_POUT,
    parameter int                N_IO        = DEF_N_IO,
    parameter int                SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int                FILT_CYCLES = DEF_FILT_CYCLES,
    parameter int                HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter logic [N_POUT-1:0] SAFE_P      = '0
) (
    input  logic              sysclk,
    input  logic              poc_n,
    input  logic              clear_pad_in,
    output logic              core_clear,
    output logic              ready,
    output logic [1:0]        state_dbg,
    input  logic [N_POUT-1:0] core_p_out,
    input  logic [N_IO-1:0]   core_io_out,
    input  logic [N_IO-1:0]   core_io_oe,
    output logic [N_IO-1:0]   core_io_in,
    output logic [N_POUT-1:0] pad_p_out,
    output logic [N_IO-1:0]   pad_io_a,
    output logic [N_IO-1:0]   pad_io_oe,
    input  logic [N_IO-1:0]   pad_io_y
);

    localparam int FW = $clog2(FILT_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    // ---------------------------------------------------------------
    // Input synchronisers
    // ---------------------------------------------------------------
    logic clr_s;

    mcs4_sync_bus #(.W(1), .STAGES(SYNC_STAGES)) u_sync_clr (
        .clk   (sysclk),
        .rst_n (poc_n),
        .d_i   (clear_pad_in),
        .q_o   (clr_s)
    );

    mcs4_sync_bus #(.W(N_IO), .STAGES(SYNC_STAGES)) u_sync_io (
        .clk   (sysclk),
        .rst_n (poc_n),
        .d_i   (pad_io_y),
        .q_o   (core_io_in)
    );

    // ---------------------------------------------------------------
    // CLEAR glitch filter: clr_f follows clr_s only after FILT_CYCLES
    // consecutive samples that disagree with it. Any agreeing sample
    // restarts the count, so short pulses are dropped.
    // ---------------------------------------------------------------
    logic          clr_f_q;
    logic [FW-1:0] filt_cnt_q;

    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            clr_f_q    <= 1'b0;
            filt_cnt_q <= '0;
        end else if (clr_s == clr_f_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FILT_LAST) begin
            clr_f_q    <= ~clr_f_q;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + FW'(1);
        end
    end

    // ---------------------------------------------------------------
    // Reset sequencer. Next state is decoded here so the output
    // registers can switch to core data on the very edge RUN is entered
    // and back to safe values on the edge it is left.
    // ---------------------------------------------------------------
    pad_state_e    state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_RESET: begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
            end
            ST_HOLD: begin
                // clr_f takes priority, so a CLEAR arriving on the
                // completing edge restarts the hold instead of releasing.
                if (clr_f_q) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_RUN: begin
                if (clr_f_q) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
            end
        endcase
    end

    logic [N_POUT-1:0] p_out_q;
    logic [N_IO-1:0]   io_a_q;
    logic [N_IO-1:0]   io_oe_q;

    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            state_q    <= ST_RESET;
            hold_cnt_q <= '0;
            p_out_q    <= SAFE_P;
            io_a_q     <= '0;
            io_oe_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            if (state_d == ST_RUN) begin
                p_out_q <= core_p_out;
                // Data is zeroed on undriven bits so the pad cell input
                // never toggles while its driver is off.
                io_a_q  <= core_io_out & core_io_oe;
                io_oe_q <= core_io_oe;
            end else begin
                p_out_q <= SAFE_P;
                io_a_q  <= '0;
                io_oe_q <= '0;
            end
        end
    end

    // Decoded from the registered state only, so both are glitch-free.
    assign core_clear = (state_q != ST_RUN);
    assign ready      = (state_q == ST_RUN);
    assign state_dbg  = state_q;

    assign pad_p_out  = p_out_q;
    assign pad_io_a   = io_a_q;
    assign pad_io_oe  = io_oe_q;

endmodule

// File: tb/tb_mcs4_pad_ctrl.sv
module tb_mcs4_pad_ctrl;

    localparam logic [9:0] SAFE = 10'h000;

    logic       sysclk = 1'b0;
    logic       clk_en = 1'b1;
    logic       poc_n;
    logic       clear_pad_in;
    logic       core_clear;
    logic       ready;
    logic [1:0] state_dbg;
    logic [9:0] core_p_out;
    logic [7:0] core_io_out;
    logic [7:0] core_io_oe;
    logic [7:0] core_io_in;
    logic [9:0] pad_p_out;
    logic [7:0] pad_io_a;
    logic [7:0] pad_io_oe;
    logic [7:0] pad_io_y;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    always #5 if (clk_en) sysclk = ~sysclk;

    mcs4_pad_ctrl dut (
        .sysclk       (sysclk),
        .poc_n        (poc_n),
        .clear_pad_in (clear_pad_in),
        .core_clear   (core_clear),
        .ready        (ready),
        .state_dbg    (state_dbg),
        .core_p_out   (core_p_out),
        .core_io_out  (core_io_out),
        .core_io_oe   (core_io_oe),
        .core_io_in   (core_io_in),
        .pad_p_out    (pad_p_out),
        .pad_io_a     (pad_io_a),
        .pad_io_oe    (pad_io_oe),
        .pad_io_y     (pad_io_y)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Advance one rising edge, then settle so outputs are sampled away from it.
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Raise CLEAR for high_len cycles; edges counted from the first edge
    // that sees it high. RUN is expected before hold_edge and from run_edge.
    task automatic clear_pulse(input int high_len, input int hold_edge,
                               input int run_edge, input int total,
                               input logic [9:0] run_p);
        logic exp_run;
        clear_pad_in = 1'b1;
        for (int e = 1; e <= total; e++) begin
            tick();
            exp_run = (e < hold_edge) || (e >= run_edge);
            check_eq($sformatf("clr_ready_e%0d", e), ready, exp_run);
            check_eq($sformatf("clr_core_clear_e%0d", e), core_clear, !exp_run);
            if (!exp_run) begin
                check_eq($sformatf("clr_safe_p_e%0d", e), pad_p_out, SAFE);
                check_eq($sformatf("clr_safe_oe_e%0d", e), pad_io_oe, 8'h00);
            end
            if (e == run_edge)
                check_eq("clr_rerun_p", pad_p_out, run_p);
            if (e == high_len)
                clear_pad_in = 1'b0;
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        poc_n        = 1'b0;
        clear_pad_in = 1'b0;
        core_p_out   = 10'h3FF;
        core_io_out  = 8'hFF;
        core_io_oe   = 8'hFF;
        pad_io_y     = 8'h00;
        repeat (3) tick();

        // Reset values while poc_n is low, clock running.
        check_eq("rst_state", state_dbg, 2'd0);
        check_eq("rst_core_clear", core_clear, 1'b1);
        check_eq("rst_ready", ready, 1'b0);
        check_eq("rst_p_out", pad_p_out, SAFE);
        check_eq("rst_io_a", pad_io_a, 8'h00);
        check_eq("rst_io_oe", pad_io_oe, 8'h00);
        check_eq("rst_io_in", core_io_in, 8'h00);

        // Release: RUN on edge 17, safe outputs until then.
        poc_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            check_eq($sformatf("seq_ready_e%0d", e), ready, 1'b0);
            check_eq($sformatf("seq_core_clear_e%0d", e), core_clear, 1'b1);
            check_eq($sformatf("seq_p_out_e%0d", e), pad_p_out, SAFE);
            check_eq($sformatf("seq_io_oe_e%0d", e), pad_io_oe, 8'h00);
            if (e == 1) check_eq("seq_state_hold", state_dbg, 2'd1);
            // Input sync in HOLD: change after edge 4, visible after edge 6.
            if (e == 4) pad_io_y = 8'h5A;
            if (e == 5) check_eq("hold_io_in_1", core_io_in, 8'h00);
            if (e == 6) check_eq("hold_io_in_2", core_io_in, 8'h5A);
        end
        tick();
        check_eq("run_ready", ready, 1'b1);
        check_eq("run_core_clear", core_clear, 1'b0);
        check_eq("run_state", state_dbg, 2'd2);
        check_eq("run_first_p", pad_p_out, 10'h3FF);
        check_eq("run_first_oe", pad_io_oe, 8'hFF);
        check_eq("run_first_a", pad_io_a, 8'hFF);

        // Core data with partial output enable.
        core_p_out  = 10'h2A5;
        core_io_out = 8'hC3;
        core_io_oe  = 8'h0F;
        tick();
        check_eq("data_p", pad_p_out, 10'h2A5);
        check_eq("data_a", pad_io_a, 8'h03);
        check_eq("data_oe", pad_io_oe, 8'h0F);

        // Input sync in RUN.
        pad_io_y = 8'h3C;
        tick();
        check_eq("run_io_in_1", core_io_in, 8'h5A);
        tick();
        check_eq("run_io_in_2", core_io_in, 8'h3C);

        // 3-cycle CLEAR glitch: filtered, RUN throughout.
        clear_pulse(3, 100, 100, 12, 10'h2A5);
        // 4-cycle CLEAR: HOLD on edge 2+4+1, clr_f drops on edge 10, RUN 16 edges later.
        clear_pulse(4, 7, 26, 26, 10'h2A5);
        // 40-cycle CLEAR: clr_f drops on edge 46, RUN on edge 62.
        clear_pulse(40, 7, 62, 62, 10'h2A5);

        // poc_n mid-RUN with the clock stopped.
        clk_en = 1'b0;
        #20;
        poc_n = 1'b0;
        #1;
        check_eq("poc_state", state_dbg, 2'd0);
        check_eq("poc_core_clear", core_clear, 1'b1);
        check_eq("poc_ready", ready, 1'b0);
        check_eq("poc_p_out", pad_p_out, SAFE);
        check_eq("poc_io_a", pad_io_a, 8'h00);
        check_eq("poc_io_oe", pad_io_oe, 8'h00);
        check_eq("poc_io_in", core_io_in, 8'h00);

        // Sequence restarts after release.
        clk_en = 1'b1;
        repeat (2) tick();
        poc_n = 1'b1;
        repeat (16) tick();
        check_eq("restart_ready_e16", ready, 1'b0);
        tick();
        check_eq("restart_ready_e17", ready, 1'b1);
        check_eq("restart_p", pad_p_out, 10'h2A5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
